// File: rtl/sipo_deser_if.sv
// sipo_deser_if: bundles the serial link input, the parallel valid/ready
// output and the sideband control/status of the deserializer.
//   master : serial source / parallel consumer side (drives serial_in,
//            bit_valid, sync_clr, out_ready, overrun_clr)
//   slave  : the deserializer itself (drives parallel_out, out_valid,
//            overrun, bit_count)
interface sipo_deser_if #(
  parameter int WIDTH = 16
) ();
  logic                     serial_in;
  logic                     bit_valid;
  logic                     sync_clr;
  logic [WIDTH-1:0]         parallel_out;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overrun;
  logic                     overrun_clr;
  logic [$clog2(WIDTH)-1:0] bit_count;

  modport master (
    output serial_in, bit_valid, sync_clr, out_ready, overrun_clr,
    input  parallel_out, out_valid, overrun, bit_count
  );

  modport slave (
    input  serial_in, bit_valid, sync_clr, out_ready, overrun_clr,
    output parallel_out, out_valid, overrun, bit_count
  );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: receive end of the LSB-first serial shift link. Assembles
// WIDTH-bit words from qualified serial bits and presents each one on a
// one-entry valid/ready output register, flagging words dropped while the
// consumer stalls.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sipo_deser_if.slave (serial_in, bit_valid, sync_clr,
//            out_ready, overrun_clr in; parallel_out, out_valid, overrun,
//            bit_count out)
//
// Output register FSM:
//   state | meaning
//   EMPTY | no unconsumed word, out_valid=0
//   FULL  | parallel_out holds an unconsumed word, out_valid=1
module sipo_deser #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  sipo_deser_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shift_nxt;
  logic             take_bit;
  logic             complete;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_nxt = {sreg_q[WIDTH-2:0], bus.serial_in};
    end else begin : g_lsb
      assign shift_nxt = {bus.serial_in, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  // sync_clr wins over a simultaneous bit, so that bit can never complete a word
  assign take_bit = bus.bit_valid && !bus.sync_clr;
  assign complete = take_bit && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (bus.sync_clr) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (bus.bit_valid) begin
      sreg_d = shift_nxt;
      cnt_d  = complete ? '0 : cnt_q + CW'(1);
    end
  end

  // Completed word comes from shift_nxt so the completing bit is included
  always_comb begin
    state_d = state_q;
    pout_d  = pout_q;
    ovr_d   = ovr_q && !bus.overrun_clr;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          pout_d  = shift_nxt;
        end
      end
      FULL: begin
        if (complete && bus.out_ready) begin
          pout_d = shift_nxt;
        end else if (complete) begin
          // held word wins; the new one is dropped and the drop is recorded
          ovr_d = 1'b1;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sreg_q  <= '0;
      cnt_q   <= '0;
      pout_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.parallel_out = pout_q;
  assign bus.out_valid    = (state_q == FULL);
  assign bus.overrun      = ovr_q;
  assign bus.bit_count    = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: two instances (LSB-first and MSB-first) share the
// same stimulus; a word-level reference model predicts every output each
// cycle, plus directed checks of specific words.
module tb_sipo_deser;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  sipo_deser_if #(.WIDTH(W)) bus0 ();
  sipo_deser_if #(.WIDTH(W)) bus1 ();

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state, index 0 = LSB-first, 1 = MSB-first
  int         nbits [2];
  logic [W-1:0] acc [2];
  logic [W-1:0] mdata [2];
  bit         mvalid [2];
  bit         movr [2];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      nbits[d] = 0; acc[d] = '0; mdata[d] = '0; mvalid[d] = 0; movr[d] = 0;
    end
  endtask

  task automatic check_all();
    chk("pout0", bus0.parallel_out, mdata[0]);
    chk("valid0", W'(bus0.out_valid), W'(mvalid[0]));
    chk("ovr0", W'(bus0.overrun), W'(movr[0]));
    chk("bcnt0", W'(bus0.bit_count), W'(nbits[0]));
    chk("pout1", bus1.parallel_out, mdata[1]);
    chk("valid1", W'(bus1.out_valid), W'(mvalid[1]));
    chk("ovr1", W'(bus1.overrun), W'(movr[1]));
    chk("bcnt1", W'(bus1.bit_count), W'(nbits[1]));
  endtask

  // Word-level model: bit k of a word goes to position k (LSB-first) or
  // W-1-k (MSB-first); a word is complete when its W-th bit arrives.
  task automatic model_edge(input bit sin, input bit bv, input bit sc, input bit ordy, input bit oclr);
    logic [W-1:0] w;
    bit comp;
    int pos;
    for (int d = 0; d < 2; d++) begin
      w = acc[d];
      comp = 0;
      if (!sc && bv) begin
        pos = (d == 1) ? (W - 1 - nbits[d]) : nbits[d];
        w[pos] = sin;
        comp = (nbits[d] == W - 1);
      end
      if (sc) begin
        nbits[d] = 0; acc[d] = '0;
      end else if (bv) begin
        if (comp) begin nbits[d] = 0; acc[d] = '0; end
        else begin nbits[d]++; acc[d] = w; end
      end
      if (oclr) movr[d] = 0;
      if (comp) begin
        if (!mvalid[d] || ordy) begin mvalid[d] = 1; mdata[d] = w; end
        else movr[d] = 1;
      end else if (mvalid[d] && ordy) begin
        mvalid[d] = 0;
      end
    end
  endtask

  task automatic tick(input bit sin, input bit bv, input bit sc, input bit ordy, input bit oclr);
    bus0.serial_in = sin; bus0.bit_valid = bv; bus0.sync_clr = sc;
    bus0.out_ready = ordy; bus0.overrun_clr = oclr;
    bus1.serial_in = sin; bus1.bit_valid = bv; bus1.sync_clr = sc;
    bus1.out_ready = ordy; bus1.overrun_clr = oclr;
    @(posedge clk);
    model_edge(sin, bv, sc, ordy, oclr);
    #1;
    check_all();
  endtask

  // msb_order=1 sends word[W-1] first; maxgap idle cycles before each bit
  task automatic send_word(input logic [W-1:0] word, input bit msb_order, input int maxgap, input bit ordy);
    logic [W-1:0] wv;
    wv = word;
    for (int i = 0; i < W; i++) begin
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        for (int k = 0; k < g; k++) tick(1'b0, 1'b0, 1'b0, ordy, 1'b0);
      end
      tick(msb_order ? wv[W-1-i] : wv[i], 1'b1, 1'b0, ordy, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] v;
    rst_n = 1'b0;
    bus0.serial_in = 0; bus0.bit_valid = 0; bus0.sync_clr = 0; bus0.out_ready = 0; bus0.overrun_clr = 0;
    bus1.serial_in = 0; bus1.bit_valid = 0; bus1.sync_clr = 0; bus1.out_ready = 0; bus1.overrun_clr = 0;
    model_reset();
    #3;
    check_all();
    #9;
    rst_n = 1'b1;

    // 1: continuous word, consumer ready
    send_word(16'hA5C3, 1'b0, 0, 1'b1);
    chk("t1_valid", W'(bus0.out_valid), W'(1));
    chk("t1_word", bus0.parallel_out, 16'hA5C3);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_drain", W'(bus0.out_valid), W'(0));
    chk("t1_ovr", W'(bus0.overrun), W'(0));

    // 2: same word with random gaps
    send_word(16'hA5C3, 1'b0, 3, 1'b1);
    chk("t2_word", bus0.parallel_out, 16'hA5C3);
    chk("t2_bcnt", W'(bus0.bit_count), W'(0));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 3: stalled consumer, overrun, drain, clear
    send_word(16'h1111, 1'b0, 0, 1'b0);
    send_word(16'h2222, 1'b0, 1, 1'b0);
    chk("t3_hold", bus0.parallel_out, 16'h1111);
    chk("t3_ovr", W'(bus0.overrun), W'(1));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_drain", W'(bus0.out_valid), W'(0));
    chk("t3_keep", bus0.parallel_out, 16'h1111);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", W'(bus0.overrun), W'(0));

    // overrun set beats a simultaneous clear
    send_word(16'h0F0F, 1'b0, 0, 1'b0);
    v = 16'h3C3C;
    for (int i = 0; i < W - 1; i++) tick(v[i], 1'b1, 1'b0, 1'b0, 1'b0);
    tick(v[W-1], 1'b1, 1'b0, 1'b0, 1'b1);
    chk("setwins_ovr", W'(bus0.overrun), W'(1));
    chk("setwins_hold", bus0.parallel_out, 16'h0F0F);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("setwins_clr", W'(bus0.overrun), W'(0));

    // 4: back-to-back words
    send_word(16'h0001, 1'b0, 0, 1'b1);
    chk("t4_w0", bus0.parallel_out, 16'h0001);
    send_word(16'h8000, 1'b0, 0, 1'b1);
    chk("t4_w1", bus0.parallel_out, 16'h8000);
    send_word(16'hFFFF, 1'b0, 0, 1'b1);
    chk("t4_w2", bus0.parallel_out, 16'hFFFF);
    chk("t4_ovr", W'(bus0.overrun), W'(0));

    // completion in the same cycle a held word is consumed
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v = 16'h5A5A;
    for (int i = 0; i < W - 1; i++) tick(v[i], 1'b1, 1'b0, 1'b0, 1'b0);
    tick(v[W-1], 1'b1, 1'b0, 1'b1, 1'b0);
    chk("swap_word", bus0.parallel_out, 16'h5A5A);
    chk("swap_valid", W'(bus0.out_valid), W'(1));
    chk("swap_ovr", W'(bus0.overrun), W'(0));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 5: sync_clr with a simultaneous bit, then reset mid-word
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_clr_bcnt", W'(bus0.bit_count), W'(0));
    send_word(16'h1234, 1'b0, 2, 1'b1);
    chk("t5_word", bus0.parallel_out, 16'h1234);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    send_word(16'hBEEF, 1'b0, 0, 1'b1);
    chk("t5_beef", bus0.parallel_out, 16'hBEEF);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 6: MSB-first instance
    send_word(16'hC001, 1'b1, 1, 1'b1);
    chk("t6_msb", bus1.parallel_out, 16'hC001);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // random traffic with random ready, gaps, clears
    for (int n = 0; n < 400; n++) begin
      tick(1'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(40, 0) == 0),
           1'($urandom), ($urandom_range(20, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
